// File: rtl/dsp_pkg.sv
// Types and constants shared between the DSP multiply-add stage and its result stream.
package dsp_pkg;

    localparam int DSP_DW      = 8;
    localparam int DSP_LATENCY = 3;
    localparam int OVF_CNT_W   = 16;

    typedef struct packed {
        logic                     ovf;
        logic signed [DSP_DW-1:0] data;
    } dsp_result_t;

endpackage

// File: rtl/dsp_result_stream_chk.sv
// Protocol checker: the credit scheme must never let a capture meet a full FIFO.
module dsp_result_stream_chk (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic full
);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is visible on rdata whenever not empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok_s, pop_ok_s;

    // Next-state for pointers and occupancy; pushes into a full FIFO are dropped.
    always_comb begin
        push_ok_s = push && (level_q != LW'(DEPTH));
        pop_ok_s  = pop && (level_q != LW'(0));
        wptr_d    = push_ok_s ? wptr_q + AW'(1) : wptr_q;
        rptr_d    = pop_ok_s  ? rptr_q + AW'(1) : rptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign empty = (level_q == LW'(0));
    assign full  = (level_q == LW'(DEPTH));
    assign level = level_q;
    assign rdata = empty ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/dsp_result_stream.sv
// Captures DSP results for issued operands LATENCY cycles later and streams them out as AXI-Stream packets.
module dsp_result_stream
    import dsp_pkg::*;
#(
    parameter int DW      = DSP_DW,
    parameter int LATENCY = DSP_LATENCY,
    parameter int DEPTH   = 8,
    parameter int PKT_LEN = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [DW-1:0]              dsp_data,
    input  logic                       dsp_ovf,
    output logic [DW-1:0]              m_axis_tdata,
    output logic                       m_axis_tuser,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [OVF_CNT_W-1:0]       ovf_count
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(PKT_LEN);

    logic [LATENCY-1:0]   vld_sr_q, vld_sr_d;
    logic [CW-1:0]        beat_q, beat_d;
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic                 accept_s, push_s, pop_s, full_s, empty_s, tlast_s;
    logic [LW-1:0]        level_s;
    dsp_result_t          push_word_s, rd_word_s;

    function automatic logic [LW:0] popcnt(input logic [LATENCY-1:0] v);
        logic [LW:0] n;
        n = '0;
        for (int i = 0; i < LATENCY; i++) begin
            n = n + {{LW{1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Credit covers both buffered and in-flight results, so it depends on registers only.
    assign issue_ready = (({1'b0, level_s} + popcnt(vld_sr_q)) < (LW+1)'(DEPTH));
    assign push_word_s = '{ovf: dsp_ovf, data: dsp_data};

    // Issue tracking, packet beat counter and saturating overflow counter.
    always_comb begin
        accept_s = issue_valid && issue_ready;
        push_s   = vld_sr_q[LATENCY-1];
        pop_s    = !empty_s && m_axis_tready;
        vld_sr_d = (vld_sr_q << 1) | LATENCY'(accept_s);
        tlast_s  = !empty_s && (beat_q == CW'(PKT_LEN-1));
        if (pop_s) begin
            beat_d = tlast_s ? '0 : beat_q + CW'(1);
        end else begin
            beat_d = beat_q;
        end
        if (pop_s && rd_word_s.ovf && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
        end else begin
            ovf_cnt_d = ovf_cnt_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr_q  <= '0;
            beat_q    <= '0;
            ovf_cnt_q <= '0;
        end else begin
            vld_sr_q  <= vld_sr_d;
            beat_q    <= beat_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH ($bits(dsp_result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata (push_word_s),
        .pop   (pop_s),
        .rdata (rd_word_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level_s)
    );

    dsp_result_stream_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .full (full_s)
    );

    assign m_axis_tvalid = !empty_s;
    assign m_axis_tdata  = rd_word_s.data;
    assign m_axis_tuser  = rd_word_s.ovf;
    assign m_axis_tlast  = tlast_s;
    assign fifo_level    = level_s;
    assign ovf_count     = ovf_cnt_q;

endmodule

// File: tb/tb_dsp_result_stream.sv
// Directed bench for dsp_result_stream with a 3-stage delay model standing in for the DSP.
module tb_dsp_result_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [7:0]  dsp_data;
    logic        dsp_ovf;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [3:0]  fifo_level;
    logic [15:0] ovf_count;

    logic [7:0]  op_data;
    logic        op_ovf;
    logic [7:0]  pd [3];
    logic        po [3];

    int n_tests = 0;
    int n_fail  = 0;

    dsp_result_stream dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .dsp_data      (dsp_data),
        .dsp_ovf       (dsp_ovf),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .fifo_level    (fifo_level),
        .ovf_count     (ovf_count)
    );

    always #5 clk = ~clk;

    // DSP stand-in: operands presented in cycle n emerge as results in cycle n+3.
    always @(posedge clk) begin
        pd[0] <= op_data; pd[1] <= pd[0]; pd[2] <= pd[1];
        po[0] <= op_ovf;  po[1] <= po[0]; po[2] <= po[1];
    end
    assign dsp_data = pd[2];
    assign dsp_ovf  = po[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; issue_valid = 1'b0; op_data = 8'h00; op_ovf = 1'b0; m_axis_tready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  op;
        logic        ovf;
        logic [7:0]  exp_data;
        logic        exp_user;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vec [5];

    initial begin
        vec[0] = '{op: 8'h81, ovf: 1'b1, exp_data: 8'h81, exp_user: 1'b1, exp_cnt: 16'd1};
        vec[1] = '{op: 8'h7F, ovf: 1'b0, exp_data: 8'h7F, exp_user: 1'b0, exp_cnt: 16'd1};
        vec[2] = '{op: 8'hC3, ovf: 1'b1, exp_data: 8'hC3, exp_user: 1'b1, exp_cnt: 16'd2};
        vec[3] = '{op: 8'h05, ovf: 1'b1, exp_data: 8'h05, exp_user: 1'b1, exp_cnt: 16'd3};
        vec[4] = '{op: 8'hFE, ovf: 1'b0, exp_data: 8'hFE, exp_user: 1'b0, exp_cnt: 16'd3};

        reset_dut();
        chk("rst_tvalid", 0, 32'(m_axis_tvalid), 32'd0);
        chk("rst_tlast",  0, 32'(m_axis_tlast),  32'd0);
        chk("rst_tdata",  0, 32'(m_axis_tdata),  32'd0);
        chk("rst_tuser",  0, 32'(m_axis_tuser),  32'd0);
        chk("rst_level",  0, 32'(fifo_level),    32'd0);
        chk("rst_ready",  0, 32'(issue_ready),   32'd1);
        chk("rst_ovfcnt", 0, 32'(ovf_count),     32'd0);

        // Single beat: issue in cycle 0, beat visible in cycle 4, drained by cycle 5.
        for (int c = 0; c < 7; c++) begin
            if (c == 3) chk("single_early", c, 32'(m_axis_tvalid), 32'd0);
            if (c == 4) begin
                chk("single_tvalid", c, 32'(m_axis_tvalid), 32'd1);
                chk("single_tdata",  c, 32'(m_axis_tdata),  32'h2A);
                chk("single_tuser",  c, 32'(m_axis_tuser),  32'd0);
                chk("single_tlast",  c, 32'(m_axis_tlast),  32'd0);
                chk("single_level",  c, 32'(fifo_level),    32'd1);
            end
            if (c == 5) begin
                chk("single_level_after", c, 32'(fifo_level),    32'd0);
                chk("single_tvalid_after", c, 32'(m_axis_tvalid), 32'd0);
            end
            issue_valid = (c == 0); op_data = 8'h2A; op_ovf = 1'b0; m_axis_tready = 1'b1;
            tick();
        end

        // Backpressure: 8 credits consumed, FIFO fills, then drains in order.
        reset_dut();
        for (int c = 0; c < 20; c++) begin
            chk("bp_ready", c, 32'(issue_ready), (c < 8) ? 32'd1 : 32'd0);
            chk("bp_level", c, 32'(fifo_level), (c < 4) ? 32'd0 : ((c - 3 > 8) ? 32'd8 : 32'(c - 3)));
            chk("bp_tvalid", c, 32'(m_axis_tvalid), (c < 4) ? 32'd0 : 32'd1);
            issue_valid = 1'b1; op_data = 8'(8'h10 + c); op_ovf = 1'b0; m_axis_tready = 1'b0;
            tick();
        end
        for (int c = 20; c < 30; c++) begin
            chk("bp_ready2", c, 32'(issue_ready), (c == 20) ? 32'd0 : 32'd1);
            if (c < 28) begin
                chk("bp_tvalid2", c, 32'(m_axis_tvalid), 32'd1);
                chk("bp_tdata",   c, 32'(m_axis_tdata),  32'(8'h10 + (c - 20)));
                chk("bp_tlast",   c, 32'(m_axis_tlast),  32'd0);
            end else begin
                chk("bp_drained", c, 32'(m_axis_tvalid), 32'd0);
                chk("bp_level0",  c, 32'(fifo_level),    32'd0);
            end
            issue_valid = 1'b0; m_axis_tready = 1'b1;
            tick();
        end

        // Overflow accounting table, back-to-back so capture and pop coincide at level 1.
        reset_dut();
        for (int c = 0; c < 11; c++) begin
            if (c >= 4 && c < 9) begin
                chk("tbl_tvalid", c, 32'(m_axis_tvalid), 32'd1);
                chk("tbl_tdata",  c, 32'(m_axis_tdata),  32'(vec[c-4].exp_data));
                chk("tbl_tuser",  c, 32'(m_axis_tuser),  32'(vec[c-4].exp_user));
            end
            if (c >= 5 && c < 10) chk("tbl_ovfcnt", c, 32'(ovf_count), 32'(vec[c-5].exp_cnt));
            chk("tbl_level", c, 32'(fifo_level), (c >= 4 && c <= 8) ? 32'd1 : 32'd0);
            issue_valid   = (c < 5);
            op_data       = (c < 5) ? vec[c].op  : 8'h00;
            op_ovf        = (c < 5) ? vec[c].ovf : 1'b0;
            m_axis_tready = 1'b1;
            tick();
        end

        // Reset mid-flight: three issues, rst in cycle 3 before their capture.
        for (int c = 0; c < 11; c++) begin
            if (c >= 4) begin
                chk("mid_tvalid", c, 32'(m_axis_tvalid), 32'd0);
                chk("mid_level",  c, 32'(fifo_level),    32'd0);
                chk("mid_ovfcnt", c, 32'(ovf_count),     32'd0);
                chk("mid_ready",  c, 32'(issue_ready),   32'd1);
            end
            rst = (c == 3); issue_valid = (c < 3); op_data = 8'h55; op_ovf = 1'b1; m_axis_tready = 1'b1;
            tick();
        end

        // Streaming 40 beats; the beat counter must have restarted at the mid-flight reset.
        for (int c = 0; c < 46; c++) begin
            chk("str_ready", c, 32'(issue_ready), 32'd1);
            if (c >= 4 && c < 44) begin
                chk("str_tvalid", c, 32'(m_axis_tvalid), 32'd1);
                chk("str_tdata",  c, 32'(m_axis_tdata),  32'(8'(c - 3)));
                chk("str_tlast",  c, 32'(m_axis_tlast),  (c - 4 == 15 || c - 4 == 31) ? 32'd1 : 32'd0);
            end else begin
                chk("str_idle", c, 32'(m_axis_tvalid), 32'd0);
            end
            issue_valid = (c < 40); op_data = 8'(c + 1); op_ovf = 1'b0; m_axis_tready = 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
